div_unit: RTL

//  Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU. Sits in the EX

---
 rtl/div_if.sv | 27 ++
 rtl/div_unit.sv | 100 ++++++++++
 2 files changed

// File: rtl/div_if.sv
// div_if: handshake bundle between the EX stage and the divider
// Ports (master = EX stage, slave = divider):
//   start      request a division; taken only when the divider is idle
//   alu_op     operation code; bits [4:2]==3'b101 mark a divide op,
//              bit 1 selects remainder, bit 0 selects unsigned
//   operand_a  dividend (rs1, already forwarded)
//   operand_b  divisor (rs2, already forwarded)
//   flush      kill any in-flight operation
//   result     quotient or remainder, valid while done=1, held afterwards
//   done       one-cycle pulse when result is valid
//   busy       high while iterating
//   stall      combinational stall request for the hazard unit
interface div_if #(parameter int XLEN = 32);
  logic            start;
  logic [4:0]      alu_op;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            flush;
  logic [XLEN-1:0] result;
  logic            done;
  logic            busy;
  logic            stall;
  modport master (output start, alu_op, operand_a, operand_b, flush,
                  input result, done, busy, stall);
  modport slave (input start, alu_op, operand_a, operand_b, flush,
                 output result, done, busy, stall);
endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   div_if.slave: start/alu_op/operand_a/operand_b/flush in,
//         result/done/busy/stall out
module div_unit #(
  parameter int XLEN  = 32,
  parameter int ITERS = XLEN
) (
  input logic  clk,
  input logic  rst,
  div_if.slave bus
);
  localparam int CW = $clog2(ITERS);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  state_e          state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rem, quo, dvs, result_q;
  logic            is_rem, q_neg, r_neg, done_q, busy_q;
  logic            accept, sgn_op, a_neg, b_neg, b_zero, ovf;
  logic [XLEN-1:0] abs_a, abs_b, special, rem_n, quo_n, fin_q, fin_r;
  logic [XLEN:0]   rem_sh, diff;
  assign accept  = bus.start && state == IDLE && bus.alu_op[4:2] == 3'b101 && !bus.flush;
  assign sgn_op  = ~bus.alu_op[0];
  assign a_neg   = sgn_op & bus.operand_a[XLEN-1];
  assign b_neg   = sgn_op & bus.operand_b[XLEN-1];
  assign abs_a   = a_neg ? -bus.operand_a : bus.operand_a;
  assign abs_b   = b_neg ? -bus.operand_b : bus.operand_b;
  assign b_zero  = bus.operand_b == '0;
  // most-negative / -1 overflows the signed quotient, so it is answered directly
  assign ovf     = sgn_op && bus.operand_a == {1'b1, {(XLEN-1){1'b0}}} && bus.operand_b == '1;
  assign special = b_zero ? (bus.alu_op[1] ? bus.operand_a : '1)
                          : (bus.alu_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
  // one restoring step: shift {rem,quo}, trial-subtract, keep if no borrow
  assign rem_sh  = {rem, quo[XLEN-1]};
  assign diff    = rem_sh - {1'b0, dvs};
  assign rem_n   = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
  assign quo_n   = {quo[XLEN-2:0], ~diff[XLEN]};
  assign fin_q   = q_neg ? -quo_n : quo_n;
  assign fin_r   = r_neg ? -rem_n : rem_n;
  assign bus.result = result_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;
  assign bus.stall  = accept || state == CALC;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      is_rem   <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.flush) begin
        state  <= IDLE;
        cnt    <= '0;
        busy_q <= 1'b0;
      end else begin
        case (state)
          IDLE: if (accept) begin
            is_rem <= bus.alu_op[1];
            q_neg  <= a_neg ^ b_neg;
            r_neg  <= a_neg;
            quo    <= abs_a;
            dvs    <= abs_b;
            rem    <= '0;
            cnt    <= '0;
            if (b_zero || ovf) begin
              state    <= DONE;
              done_q   <= 1'b1;
              result_q <= special;
            end else begin
              state  <= CALC;
              busy_q <= 1'b1;
            end
          end
          CALC: begin
            rem <= rem_n;
            quo <= quo_n;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(ITERS - 1)) begin
              state    <= DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              result_q <= is_rem ? fin_r : fin_q;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
